// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: sequences fetch, decode, memory, ALU and writeback steps.
// Optional MCTRL_MEM_STALL_EN: honour mem_ready in FETCH/MEMRD/MEMWR; otherwise memory is always ready.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       ir_write,
   output logic       iord,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic [1:0] ext_op,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REX    = 4'd6,  S_RWB   = 4'd7,
      S_BEQ    = 4'd8,  S_IEX    = 4'd9,  S_IWB    = 4'd10, S_JMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_t state_q, state_d;
   logic   mem_ok;

`ifdef MCTRL_MEM_STALL_EN
   assign mem_ok = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW:                     state_d = S_MEMADR;
               OP_RTYPE:                         state_d = S_REX;
               OP_BEQ:                           state_d = S_BEQ;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_IEX;
               OP_J:                             state_d = S_JMP;
               default:                          state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
         S_REX:    state_d = S_RWB;
         S_IEX:    state_d = S_IWB;
         default:  state_d = S_FETCH;  // writeback, BEQ, JMP and unused codes 12-15
      endcase
   end

   always_comb begin
      pc_en      = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = 3'b000;
      ext_op     = 2'b01;
      illegal_op = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_b = 2'b01;
            alu_ctrl  = 3'b010;
            ir_write  = mem_ok;
            pc_en     = mem_ok;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            alu_ctrl  = 3'b010;
            case (op)
               OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J,
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: illegal_op = 1'b0;
               default:                          illegal_op = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_ctrl  = 3'b010;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_REX: begin
            alu_src_a = 1'b1;
            case (funct)
               6'b100010: alu_ctrl = 3'b110;
               6'b100100: alu_ctrl = 3'b000;
               6'b100101: alu_ctrl = 3'b001;
               6'b101010: alu_ctrl = 3'b111;
               default:   alu_ctrl = 3'b010;
            endcase
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = 1'b1;
            alu_ctrl  = 3'b110;
            pc_src    = 2'b01;
            pc_en     = zero;
         end
         S_IEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            // lui relies on the datapath zeroing register A, so OR passes imm<<16 through
            case (op)
               OP_ANDI: begin ext_op = 2'b00; alu_ctrl = 3'b000; end
               OP_ORI:  begin ext_op = 2'b00; alu_ctrl = 3'b001; end
               OP_LUI:  begin ext_op = 2'b10; alu_ctrl = 3'b001; end
               default: begin ext_op = 2'b01; alu_ctrl = 3'b010; end
            endcase
         end
         S_IWB: reg_write = 1'b1;
         S_JMP: begin
            pc_src = 2'b10;
            pc_en  = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         pc_en      = 1'b0;
         ir_write   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         illegal_op = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level reference model (state path per opcode class plus
// per-step control table) driven by directed and randomized instructions with random memory stalls.
module tb_multicycle_ctrl;

`ifdef MCTRL_MEM_STALL_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   logic       clk, reset, zero, mem_ready;
   logic [5:0] op, funct;
   logic       pc_en, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
   logic [1:0] pc_src, alu_src_b, ext_op;
   logic [2:0] alu_ctrl;
   logic [3:0] state;

   int n_vec, n_err;
   int r_cyc, r_regw, r_memrd, r_ill, r_pcen;
   logic [1:0] r_iex_ext;
   logic [2:0] r_iex_ctrl;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .pc_src(pc_src), .ir_write(ir_write), .iord(iord), .mem_write(mem_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .ext_op(ext_op), .illegal_op(illegal_op),
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction classes: 0 lw, 1 sw, 2 R-type, 3 beq, 4 immediate, 5 jump, 6 illegal
   function automatic int op_class(input logic [5:0] o);
      if (o == OP_LW) return 0;
      if (o == OP_SW) return 1;
      if (o == OP_R) return 2;
      if (o == OP_BEQ) return 3;
      if (o == OP_ADDI || o == OP_ANDI || o == OP_ORI || o == OP_LUI) return 4;
      if (o == OP_J) return 5;
      return 6;
   endfunction

   function automatic logic [2:0] rtype_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Expected control word for one step of an instruction, with rdy the effective memory-ready
   function automatic logic [17:0] exp_ctrl(input int st, input logic [5:0] o, input logic [5:0] f,
                                            input logic z, input logic rdy);
      logic pce, ir, io, mw, rw, rd, m2r, sa, ill;
      logic [1:0] ps, sb, ext;
      logic [2:0] ac;
      {pce, ir, io, mw, rw, rd, m2r, sa, ill} = '0;
      ps = 2'b00; sb = 2'b00; ac = 3'b000; ext = 2'b01;
      case (st)
         0:  begin sb = 2'b01; ac = 3'b010; ir = rdy; pce = rdy; end
         1:  begin sb = 2'b11; ac = 3'b010; ill = (op_class(o) == 6); end
         2:  begin sa = 1'b1; sb = 2'b10; ac = 3'b010; end
         3:  io = 1'b1;
         4:  begin rw = 1'b1; m2r = 1'b1; end
         5:  begin io = 1'b1; mw = 1'b1; end
         6:  begin sa = 1'b1; ac = rtype_alu(f); end
         7:  begin rw = 1'b1; rd = 1'b1; end
         8:  begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pce = z; end
         9:  begin
                sa = 1'b1; sb = 2'b10; ac = 3'b010;
                if (o == OP_ANDI) begin ext = 2'b00; ac = 3'b000; end
                if (o == OP_ORI)  begin ext = 2'b00; ac = 3'b001; end
                if (o == OP_LUI)  begin ext = 2'b10; ac = 3'b001; end
             end
         10: rw = 1'b1;
         11: begin ps = 2'b10; pce = 1'b1; end
         default: ;
      endcase
      return {pce, ps, ir, io, mw, rw, rd, m2r, sa, sb, ac, ext, ill};
   endfunction

   // Runs one whole instruction from FETCH; fst/mst are stall cycles in FETCH and in MEMRD/MEMWR
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int fst, input int mst);
      int path[$];
      int reps, stall;
      bit waiting;
      logic rdy;
      logic [17:0] exp_w, obs_w;
      path.delete();
      path.push_back(0);
      path.push_back(1);
      case (op_class(o))
         0: begin path.push_back(2); path.push_back(3); path.push_back(4); end
         1: begin path.push_back(2); path.push_back(5); end
         2: begin path.push_back(6); path.push_back(7); end
         3: path.push_back(8);
         4: begin path.push_back(9); path.push_back(10); end
         5: path.push_back(11);
         default: ;
      endcase
      r_cyc = 0; r_regw = 0; r_memrd = 0; r_ill = 0; r_pcen = 0;
      r_iex_ext = 2'bxx; r_iex_ctrl = 3'bxxx;
      foreach (path[i]) begin
         waiting = (path[i] == 0 || path[i] == 3 || path[i] == 5);
         stall = (path[i] == 0) ? fst : mst;
         reps = (waiting && STALL_EN) ? stall + 1 : 1;
         for (int r = 0; r < reps; r++) begin
            @(negedge clk);
            reset = 1'b0; op = o; funct = f; zero = z;
            if (waiting) mem_ready = (r < stall) ? 1'b0 : 1'b1;
            else         mem_ready = 1'($urandom_range(0, 1));
            rdy = STALL_EN ? mem_ready : 1'b1;
            #1;
            r_cyc++;
            n_vec++;
            if (state !== 4'(path[i])) begin
               n_err++;
               $display("FAIL state op=%b step=%0d: got %0d, expected %0d", o, r_cyc, state, path[i]);
            end
            exp_w = exp_ctrl(path[i], o, f, z, rdy);
            obs_w = {pc_en, pc_src, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg,
                     alu_src_a, alu_src_b, alu_ctrl, ext_op, illegal_op};
            n_vec++;
            if (obs_w !== exp_w) begin
               n_err++;
               $display("FAIL ctrl op=%b funct=%b st=%0d rdy=%b: got %b, expected %b",
                        o, f, path[i], mem_ready, obs_w, exp_w);
            end
            if (reg_write === 1'b1) r_regw++;
            if (state === 4'd3) r_memrd++;
            if (illegal_op === 1'b1) r_ill++;
            if (pc_en === 1'b1 && state !== 4'd0) r_pcen++;
            if (state === 4'd9) begin r_iex_ext = ext_op; r_iex_ctrl = alu_ctrl; end
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1; op = OP_LW; zero = 1'b1;
      #1;
      n_vec++;
      if ({pc_en, ir_write, mem_write, reg_write, illegal_op} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_force: got %b, expected 00000",
                  {pc_en, ir_write, mem_write, reg_write, illegal_op});
      end
      @(negedge clk);
      #1;
      n_vec++;
      if (state !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d, expected 0", state); end
   endtask

   task automatic test_rtype;
      run_instr(OP_R, 6'b100010, 1'b0, 0, 0);
      n_vec++;
      if (r_cyc != 4) begin n_err++; $display("FAIL rtype_latency: got %0d, expected 4", r_cyc); end
      n_vec++;
      if (r_regw != 1) begin n_err++; $display("FAIL rtype_regw: got %0d, expected 1", r_regw); end
   endtask

   task automatic test_lw_stall;
      run_instr(OP_LW, 6'b000000, 1'b0, 0, 3);
      n_vec++;
      if (r_memrd != (STALL_EN ? 4 : 1)) begin
         n_err++; $display("FAIL lw_memrd_cycles: got %0d, expected %0d", r_memrd, STALL_EN ? 4 : 1);
      end
      n_vec++;
      if (r_regw != 1) begin n_err++; $display("FAIL lw_regw: got %0d, expected 1", r_regw); end
      n_vec++;
      if (r_cyc != (STALL_EN ? 8 : 5)) begin
         n_err++; $display("FAIL lw_latency: got %0d, expected %0d", r_cyc, STALL_EN ? 8 : 5);
      end
   endtask

   task automatic test_beq;
      run_instr(OP_BEQ, 6'b000000, 1'b1, 0, 0);
      n_vec++;
      if (r_pcen != 1) begin n_err++; $display("FAIL beq_taken: got %0d, expected 1", r_pcen); end
      run_instr(OP_BEQ, 6'b000000, 1'b0, 0, 0);
      n_vec++;
      if (r_pcen != 0) begin n_err++; $display("FAIL beq_not_taken: got %0d, expected 0", r_pcen); end
      n_vec++;
      if (r_cyc != 3) begin n_err++; $display("FAIL beq_latency: got %0d, expected 3", r_cyc); end
   endtask

   task automatic test_imm;
      run_instr(OP_ORI, 6'b000000, 1'b0, 0, 0);
      n_vec++;
      if ({r_iex_ext, r_iex_ctrl} !== 5'b00001) begin
         n_err++; $display("FAIL ori_iex: got %b, expected 00001", {r_iex_ext, r_iex_ctrl});
      end
      run_instr(OP_LUI, 6'b000000, 1'b0, 0, 0);
      n_vec++;
      if ({r_iex_ext, r_iex_ctrl} !== 5'b10001) begin
         n_err++; $display("FAIL lui_iex: got %b, expected 10001", {r_iex_ext, r_iex_ctrl});
      end
      n_vec++;
      if (r_cyc != 4) begin n_err++; $display("FAIL imm_latency: got %0d, expected 4", r_cyc); end
   endtask

   task automatic test_illegal;
      run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
      n_vec++;
      if (r_ill != 1) begin n_err++; $display("FAIL illegal_pulse: got %0d, expected 1", r_ill); end
      n_vec++;
      if (r_cyc != 2) begin n_err++; $display("FAIL illegal_latency: got %0d, expected 2", r_cyc); end
      run_instr(OP_J, 6'b000000, 1'b0, 0, 0);
      n_vec++;
      if (r_cyc != 3) begin n_err++; $display("FAIL jump_latency: got %0d, expected 3", r_cyc); end
   endtask

   task automatic test_reset_mid_store;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         reset = 1'b0; op = OP_SW; mem_ready = 1'b1;
      end
`ifdef MCTRL_MEM_STALL_EN
      @(negedge clk);
      mem_ready = 1'b0;
`endif
      @(negedge clk);
      mem_ready = 1'b0; reset = 1'b1;
      #1;
      n_vec++;
      if (state !== 4'd5) begin n_err++; $display("FAIL memwr_before_reset: got %0d, expected 5", state); end
      n_vec++;
      if (mem_write !== 1'b0) begin n_err++; $display("FAIL memwr_forced: got %b, expected 0", mem_write); end
      @(negedge clk);
      #1;
      n_vec++;
      if (state !== 4'd0) begin n_err++; $display("FAIL memwr_reset_state: got %0d, expected 0", state); end
   endtask

   task automatic test_store_no_stall;
      run_instr(OP_SW, 6'b000000, 1'b0, 2, 3);
      n_vec++;
      if (r_cyc != (STALL_EN ? 9 : 4)) begin
         n_err++; $display("FAIL sw_latency: got %0d, expected %0d", r_cyc, STALL_EN ? 9 : 4);
      end
   endtask

   task automatic test_random;
      logic [5:0] ops [9];
      logic [5:0] fns [5];
      logic [5:0] o, f;
      ops = '{OP_R, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      for (int n = 0; n < 60; n++) begin
         o = (($urandom_range(0, 9)) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
         f = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 4)];
         run_instr(o, f, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b0;
      n_vec = 0; n_err = 0;
      repeat (2) @(negedge clk);
      test_reset;
      test_rtype;
      test_lw_stall;
      test_beq;
      test_imm;
      test_illegal;
      test_reset_mid_store;
      test_store_no_stall;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
